// File: rtl/byte_unstriping_rx_pkg.sv
// striping_pkg: definitions shared by the 4-lane byte striper (TX) and the
// unstriper (RX). The lane FSM encodings must match on both sides so that
// lane_ptr debug values mean the same thing on either end of the link.
//   NUM_LANES   number of byte lanes
//   lane_idx_t  2-bit lane index
//   lane_state_e round-robin lane states LANE0..LANE3
//   next_lane() successor state in the deal order 0,1,2,3,0,...
package striping_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_state_e;

  function automatic lane_state_e next_lane(input lane_state_e s);
    lane_state_e n;
    case (s)
      LANE0:   n = LANE1;
      LANE1:   n = LANE2;
      LANE2:   n = LANE3;
      default: n = LANE0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/byte_unstriping_rx_if.sv
// byte_unstriping_rx_if: lane inputs and reassembled output of the unstriper.
//   valid_in[i] / data_in<i> : lane i byte, qualified per lane, no backpressure
//   valid_out / data_out     : reassembled byte stream
//   ready_in                 : downstream accept
//   overflow                 : sticky per-lane drop flags
//   lane_ptr                 : lane the reassembly FSM is waiting on (debug)
// Output handshake: a byte transfers on a posedge where valid_out && ready_in.
// Once valid_out is high, data_out stays stable until it transfers; valid_out
// never depends combinationally on ready_in. Lane inputs have no ready: a byte
// presented on a full lane is dropped and flagged in overflow.
// Modport slave is the unstriper side, master the upstream/downstream side.
interface byte_unstriping_rx_if #(
  parameter int DATA_W = 8
);
  import striping_pkg::*;

  logic [NUM_LANES-1:0] valid_in;
  logic [DATA_W-1:0]    data_in0;
  logic [DATA_W-1:0]    data_in1;
  logic [DATA_W-1:0]    data_in2;
  logic [DATA_W-1:0]    data_in3;
  logic                 ready_in;
  logic                 valid_out;
  logic [DATA_W-1:0]    data_out;
  logic [NUM_LANES-1:0] overflow;
  lane_idx_t            lane_ptr;

  modport slave (
    input  valid_in, data_in0, data_in1, data_in2, data_in3, ready_in,
    output valid_out, data_out, overflow, lane_ptr
  );

  modport master (
    output valid_in, data_in0, data_in1, data_in2, data_in3, ready_in,
    input  valid_out, data_out, overflow, lane_ptr
  );

endinterface

// File: rtl/byte_unstriping_rx_lane_fifo.sv
// lane_fifo: single-lane circular FIFO absorbing inter-lane skew.
//   clk, reset : posedge clock, synchronous active-low reset (empties FIFO)
//   push       : write push_data (accepted when not full, or when popping)
//   pop        : remove head (ignored when empty)
//   head       : oldest entry, valid while !empty
//   empty/full : occupancy flags, full when count == FIFO_DEPTH
module lane_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees the head slot this edge, so a full FIFO still takes the push.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/byte_unstriping_rx.sv
// byte_unstriping_rx: reassembles bytes dealt round-robin over 4 lanes
// (lane order 0,1,2,3,0,...) into one serial stream.
//   clk, reset : posedge clock, synchronous active-low reset
//   bus        : byte_unstriping_rx_if slave (lane inputs, output handshake,
//                overflow flags, lane_ptr debug)
// One FIFO per lane absorbs skew; a round-robin FSM pops the lane it is
// waiting on into a registered output stage and stalls (never skips) while
// that lane is empty, which keeps the original byte order.
module byte_unstriping_rx
  import striping_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  byte_unstriping_rx_if.slave  bus
);

  logic [DATA_W-1:0]    lane_data [NUM_LANES];
  logic [DATA_W-1:0]    head      [NUM_LANES];
  logic [NUM_LANES-1:0] push, pop, empty, full;

  lane_state_e          state_q, state_d;
  logic                 valid_out_q, valid_out_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic [NUM_LANES-1:0] overflow_q, overflow_d;
  logic                 load;

  assign lane_data[0] = bus.data_in0;
  assign lane_data[1] = bus.data_in1;
  assign lane_data[2] = bus.data_in2;
  assign lane_data[3] = bus.data_in3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[i]),
      .push_data(lane_data[i]),
      .pop      (pop[i]),
      .head     (head[i]),
      .empty    (empty[i]),
      .full     (full[i])
    );
  end

  always_comb begin
    // Output stage is free when empty or being drained this edge.
    load = (!valid_out_q || bus.ready_in) && !empty[state_q];
    pop  = '0;
    if (load) pop[state_q] = 1'b1;
    push       = bus.valid_in & (~full | pop);
    overflow_d = overflow_q | (bus.valid_in & full & ~pop);

    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    state_d     = state_q;
    if (load) begin
      valid_out_d = 1'b1;
      data_out_d  = head[state_q];
      state_d     = next_lane(state_q);
    end else if (bus.ready_in) begin
      // Byte taken with nothing to replace it; data_out keeps its last value.
      valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LANE0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      overflow_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.lane_ptr  = lane_idx_t'(state_q);

endmodule
